pifo_calendar_param: RTL

Parametrised successor to the single-root PIFO calendar. It stores up to PIFO_CALENDAR_SIZE (rank, buffer address) entries as a sorted shift-register array, smallest rank first, with FIFO order among equal ranks. It supports insert and pop in the same cycle and a selectable full-calendar policy, either tail-drop or evict-largest. It reports every dropped buffer address so the buffer manager can reclaim it. It sits between the enqueue agent (rank/address producer) and the dequeue/egress scheduler.

---
 rtl/pifo_calendar_param_if.sv | 45 ++++
 rtl/pifo_calendar_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pifo_calendar_param_if.sv
// pifo_calendar_param_if
//   Bundles the insert/pop request side and the result/status side of the
//   PIFO calendar.
//   s_axis_*  : insert (rank, buffer address) and pop requests, driven by
//               the enqueue agent and the egress scheduler.
//   m_axis_*  : registered pop result, drop report, head rank and occupancy
//               status, driven by the calendar.
//   modport master : the agent/scheduler side.
//   modport slave  : the calendar side.
interface pifo_calendar_param_if #(
  parameter int unsigned RANK_WIDTH                = 16,
  parameter int unsigned BUFFER_ADDR_WIDTH         = 12,
  parameter int unsigned PIFO_CALENDAR_INDEX_WIDTH = 4
);
  logic                                 s_axis_insert_en;
  logic [RANK_WIDTH-1:0]                s_axis_rank;
  logic [BUFFER_ADDR_WIDTH-1:0]         s_axis_buffer_addr;
  logic                                 s_axis_pop_en;
  logic                                 m_axis_pop_valid;
  logic [RANK_WIDTH-1:0]                m_axis_pop_rank;
  logic [BUFFER_ADDR_WIDTH-1:0]         m_axis_buffer_addr;
  logic [RANK_WIDTH-1:0]                m_axis_pifo_calendar_top;
  logic                                 m_axis_top_valid;
  logic                                 m_axis_calendar_full;
  logic                                 m_axis_calendar_empty;
  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] m_axis_calendar_count;
  logic                                 m_axis_drop_valid;
  logic [BUFFER_ADDR_WIDTH-1:0]         m_axis_drop_addr;

  modport master (
    output s_axis_insert_en, s_axis_rank, s_axis_buffer_addr, s_axis_pop_en,
    input  m_axis_pop_valid, m_axis_pop_rank, m_axis_buffer_addr,
           m_axis_pifo_calendar_top, m_axis_top_valid, m_axis_calendar_full,
           m_axis_calendar_empty, m_axis_calendar_count, m_axis_drop_valid,
           m_axis_drop_addr
  );

  modport slave (
    input  s_axis_insert_en, s_axis_rank, s_axis_buffer_addr, s_axis_pop_en,
    output m_axis_pop_valid, m_axis_pop_rank, m_axis_buffer_addr,
           m_axis_pifo_calendar_top, m_axis_top_valid, m_axis_calendar_full,
           m_axis_calendar_empty, m_axis_calendar_count, m_axis_drop_valid,
           m_axis_drop_addr
  );
endinterface

// File: rtl/pifo_calendar_param.sv
// pifo_calendar_param
//   Sorted shift-register PIFO calendar holding up to PIFO_CALENDAR_SIZE
//   (rank, buffer address) entries, smallest rank at entry[0], FIFO order
//   among equal ranks. Supports insert, pop, and insert+pop in one cycle.
//   On insert into a full calendar, FULL_POLICY selects tail-drop (0) or
//   evict-largest when the incoming rank is strictly smaller (1); every
//   discarded buffer address is reported on the drop port.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : pifo_calendar_param_if.slave -- requests in, registered results
//          and post-update status out
module pifo_calendar_param #(
  parameter int unsigned PIFO_CALENDAR_SIZE        = 10,
  parameter int unsigned RANK_WIDTH                = 16,
  parameter int unsigned BUFFER_ADDR_WIDTH         = 12,
  parameter int unsigned PIFO_CALENDAR_INDEX_WIDTH = 4,
  parameter int unsigned FULL_POLICY               = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  pifo_calendar_param_if.slave  bus
);
  localparam int unsigned SIZE = PIFO_CALENDAR_SIZE;
  localparam int unsigned IW   = PIFO_CALENDAR_INDEX_WIDTH;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_POP,
    OP_INSERT,
    OP_INSERT_POP,
    OP_EVICT,
    OP_DROP
  } op_e;

  logic [RANK_WIDTH-1:0]        rank_q [SIZE];
  logic [RANK_WIDTH-1:0]        rank_d [SIZE];
  logic [BUFFER_ADDR_WIDTH-1:0] addr_q [SIZE];
  logic [BUFFER_ADDR_WIDTH-1:0] addr_d [SIZE];
  logic [IW-1:0]                count_q;
  logic [IW-1:0]                count_d;

  op_e         op;
  int unsigned count_i;
  int unsigned search_start;
  int unsigned pos;
  logic        is_empty;
  logic        is_full;
  logic        pop_ok;

  always_comb begin
    count_i  = 32'(count_q);
    is_empty = (count_i == 0);
    is_full  = (count_i == SIZE);
    pop_ok   = bus.s_axis_pop_en && !is_empty;
  end

  // Operation decode. Insert+pop on a non-empty calendar is always
  // accepted, even when full, since the pop frees the slot the insert uses.
  always_comb begin
    op = OP_IDLE;
    if (bus.s_axis_insert_en) begin
      if (pop_ok) begin
        op = OP_INSERT_POP;
      end else if (!is_full) begin
        op = OP_INSERT;
      end else if (FULL_POLICY == 1 && bus.s_axis_rank < rank_q[SIZE-1]) begin
        op = OP_EVICT;
      end else begin
        op = OP_DROP;
      end
    end else if (pop_ok) begin
      op = OP_POP;
    end
  end

  // Insert position in the current array: first valid slot whose rank is
  // strictly greater than the incoming one, else count. When the head is
  // popped in the same cycle the search skips entry[0].
  always_comb begin
    search_start = pop_ok ? 1 : 0;
    pos          = count_i;
    for (int unsigned i = SIZE; i > 0; i--) begin
      if ((i - 1) >= search_start && (i - 1) < count_i &&
          bus.s_axis_rank < rank_q[i-1]) begin
        pos = i - 1;
      end
    end
  end

  // Next-state array. For insert+pop the new entry lands at pos-1 in the
  // shifted-down array: slots below it take entry[j+1], slots above keep
  // entry[j], so both shifts collapse into one per-slot mux.
  always_comb begin
    for (int unsigned j = 0; j < SIZE; j++) begin
      rank_d[j] = rank_q[j];
      addr_d[j] = addr_q[j];
    end
    count_d = count_q;
    case (op)
      OP_POP: begin
        for (int unsigned j = 0; j < SIZE - 1; j++) begin
          rank_d[j] = rank_q[j+1];
          addr_d[j] = addr_q[j+1];
        end
        count_d = count_q - IW'(1);
      end
      OP_INSERT, OP_EVICT: begin
        if (pos == 0) begin
          rank_d[0] = bus.s_axis_rank;
          addr_d[0] = bus.s_axis_buffer_addr;
        end
        for (int unsigned j = 1; j < SIZE; j++) begin
          if (j == pos) begin
            rank_d[j] = bus.s_axis_rank;
            addr_d[j] = bus.s_axis_buffer_addr;
          end else if (j > pos) begin
            rank_d[j] = rank_q[j-1];
            addr_d[j] = addr_q[j-1];
          end
        end
        if (op == OP_INSERT) begin
          count_d = count_q + IW'(1);
        end
      end
      OP_INSERT_POP: begin
        for (int unsigned j = 0; j < SIZE - 1; j++) begin
          if (j + 1 < pos) begin
            rank_d[j] = rank_q[j+1];
            addr_d[j] = addr_q[j+1];
          end else if (j + 1 == pos) begin
            rank_d[j] = bus.s_axis_rank;
            addr_d[j] = bus.s_axis_buffer_addr;
          end
        end
        if (pos == SIZE) begin
          rank_d[SIZE-1] = bus.s_axis_rank;
          addr_d[SIZE-1] = bus.s_axis_buffer_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < SIZE; j++) begin
        rank_q[j] <= '0;
        addr_q[j] <= '0;
      end
      count_q                      <= '0;
      bus.m_axis_pop_valid         <= 1'b0;
      bus.m_axis_pop_rank          <= '0;
      bus.m_axis_buffer_addr       <= '0;
      bus.m_axis_pifo_calendar_top <= '0;
      bus.m_axis_top_valid         <= 1'b0;
      bus.m_axis_calendar_full     <= 1'b0;
      bus.m_axis_calendar_empty    <= 1'b1;
      bus.m_axis_calendar_count    <= '0;
      bus.m_axis_drop_valid        <= 1'b0;
      bus.m_axis_drop_addr         <= '0;
    end else begin
      rank_q  <= rank_d;
      addr_q  <= addr_d;
      count_q <= count_d;

      bus.m_axis_pop_valid <= (op == OP_POP) || (op == OP_INSERT_POP);
      if (op == OP_POP || op == OP_INSERT_POP) begin
        bus.m_axis_pop_rank    <= rank_q[0];
        bus.m_axis_buffer_addr <= addr_q[0];
      end

      bus.m_axis_drop_valid <= (op == OP_EVICT) || (op == OP_DROP);
      if (op == OP_EVICT) begin
        bus.m_axis_drop_addr <= addr_q[SIZE-1];
      end else if (op == OP_DROP) begin
        bus.m_axis_drop_addr <= bus.s_axis_buffer_addr;
      end

      bus.m_axis_pifo_calendar_top <= (count_d != '0) ? rank_d[0] : '0;
      bus.m_axis_top_valid         <= (count_d != '0);
      bus.m_axis_calendar_full     <= (count_d == IW'(SIZE));
      bus.m_axis_calendar_empty    <= (count_d == '0);
      bus.m_axis_calendar_count    <= count_d;
    end
  end
endmodule
